// File: rtl/fixed_bcd_formatter.sv
// fixed_bcd_formatter - signed Q17.14 to sign + 6 integer BCD digits + FRAC_DIGITS fraction digits.
// Integer part by serial double-dabble, fraction by repeated x10; one job at a time, extra inputs dropped.
module fixed_bcd_formatter #(
   parameter int FRAC_DIGITS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_in,
   input  logic [31:0]                result_in,
   input  logic                       overflow_in,
   output logic                       busy,
   output logic                       drop,
   output logic                       valid_out,
   output logic                       sign,
   output logic [23:0]                int_bcd,
   output logic [4*FRAC_DIGITS-1:0]   frac_bcd,
   output logic [2:0]                 int_ndigits,
   output logic                       error
);

   localparam int FW = 4 * FRAC_DIGITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INT_CONV,
      S_FRAC_CONV,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic            neg_q, neg_d;
   logic [17:0]     ipart_q, ipart_d;
   logic [13:0]     f_q, f_d;
   logic [23:0]     bcd_q, bcd_d;
   logic [FW-1:0]   fdig_q, fdig_d;
   logic [4:0]      cnt_q, cnt_d;

   logic            valid_out_q, valid_out_d;
   logic            sign_q, sign_d;
   logic [23:0]     int_bcd_q, int_bcd_d;
   logic [FW-1:0]   frac_bcd_q, frac_bcd_d;
   logic [2:0]      int_nd_q, int_nd_d;
   logic            error_q, error_d;

   logic [31:0]     mag;
   logic [23:0]     adj;
   logic [17:0]     prod;
   logic [2:0]      nd;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         neg_q       <= 1'b0;
         ipart_q     <= '0;
         f_q         <= '0;
         bcd_q       <= '0;
         fdig_q      <= '0;
         cnt_q       <= '0;
         valid_out_q <= 1'b0;
         sign_q      <= 1'b0;
         int_bcd_q   <= '0;
         frac_bcd_q  <= '0;
         int_nd_q    <= 3'd1;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         neg_q       <= neg_d;
         ipart_q     <= ipart_d;
         f_q         <= f_d;
         bcd_q       <= bcd_d;
         fdig_q      <= fdig_d;
         cnt_q       <= cnt_d;
         valid_out_q <= valid_out_d;
         sign_q      <= sign_d;
         int_bcd_q   <= int_bcd_d;
         frac_bcd_q  <= frac_bcd_d;
         int_nd_q    <= int_nd_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      neg_d       = neg_q;
      ipart_d     = ipart_q;
      f_d         = f_q;
      bcd_d       = bcd_q;
      fdig_d      = fdig_q;
      cnt_d       = cnt_q;
      valid_out_d = 1'b0;
      sign_d      = sign_q;
      int_bcd_d   = int_bcd_q;
      frac_bcd_d  = frac_bcd_q;
      int_nd_d    = int_nd_q;
      error_d     = error_q;

      // Most negative input keeps magnitude 0x8000_0000 through plain two's complement.
      mag  = result_in[31] ? (~result_in + 32'd1) : result_in;
      prod = {4'd0, f_q} * 18'd10;
      adj  = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      nd = 3'd1;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            nd = 3'(i + 1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               if (overflow_in) begin
                  state_d = S_ERR;
               end else begin
                  neg_d   = result_in[31];
                  ipart_d = mag[31:14];
                  f_d     = mag[13:0];
                  bcd_d   = '0;
                  fdig_d  = '0;
                  cnt_d   = '0;
                  state_d = S_INT_CONV;
               end
            end
         end
         S_INT_CONV: begin
            bcd_d   = (adj << 1) | 24'(ipart_q[17]);
            ipart_d = ipart_q << 1;
            if (cnt_q == 5'd17) begin
               cnt_d   = '0;
               state_d = S_FRAC_CONV;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_FRAC_CONV: begin
            f_d    = prod[13:0];
            fdig_d = (fdig_q << 4) | FW'(prod[17:14]);
            if (cnt_q == 5'(FRAC_DIGITS - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_DONE: begin
            valid_out_d = 1'b1;
            error_d     = 1'b0;
            sign_d      = neg_q && ((bcd_q != '0) || (fdig_q != '0));
            int_bcd_d   = bcd_q;
            frac_bcd_d  = fdig_q;
            int_nd_d    = nd;
            state_d     = S_IDLE;
         end
         S_ERR: begin
            valid_out_d = 1'b1;
            error_d     = 1'b1;
            sign_d      = 1'b0;
            int_bcd_d   = '0;
            frac_bcd_d  = '0;
            int_nd_d    = 3'd1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign drop        = valid_in && busy;
   assign valid_out   = valid_out_q;
   assign sign        = sign_q;
   assign int_bcd     = int_bcd_q;
   assign frac_bcd    = frac_bcd_q;
   assign int_ndigits = int_nd_q;
   assign error       = error_q;

endmodule
